tt_um_carlosgs99_div_8by4: RTL and testbench

Sequential 8-bit by 4-bit unsigned restoring divider. It is the inverse companion to the 4x4 combinational multiplier: it takes an 8-bit dividend, such as a product from that multiplier, and a 4-bit divisor, and returns the quotient and remainder. It retires one quotient bit per clock behind a start/busy/done handshake. It is a standalone Tiny Tapeout user block driven by a testbench or by the top-level IO.

---
 rtl/tt_um_carlosgs99_div_8by4.sv | 113 +++++++++++
 tb/tb_tt_um_carlosgs99_div_8by4.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_carlosgs99_div_8by4.sv
// rtl/tt_um_carlosgs99_div_8by4.sv - 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   io_Dividend    8-bit unsigned dividend, sampled when a start is accepted
//   io_Divisor     4-bit unsigned divisor, sampled when a start is accepted
//   io_start       request; accepted on a clock edge while io_busy is low
//   io_Quotient    registered quotient (8'hFF on divide by zero)
//   io_Remainder   registered remainder (dividend[3:0] on divide by zero)
//   io_busy        high while the eight iterations are running
//   io_done        one-cycle pulse when the result registers update
//   io_div_by_zero set with done when the divisor was zero, held with the results
module tt_um_carlosgs99_div_8by4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] io_Dividend,
  input  logic [3:0] io_Divisor,
  input  logic       io_start,
  output logic [7:0] io_Quotient,
  output logic [3:0] io_Remainder,
  output logic       io_busy,
  output logic       io_done,
  output logic       io_div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] d;      // dividend shifts out of the top, quotient shifts in at the bottom
  logic [3:0] v;      // latched divisor
  logic [3:0] pr;     // partial remainder, always < v
  logic [2:0] cnt;    // iteration index

  logic [4:0] t;
  logic       qbit;
  logic [3:0] pr_sub;
  logic [3:0] pr_next;
  logic [7:0] d_next;

  // One restoring step. Because pr < v, the true difference t - v is below v,
  // so the 4-bit subtraction of the low bits is exact whenever qbit is set.
  always_comb begin
    t       = {pr, d[7]};
    qbit    = (t >= {1'b0, v});
    pr_sub  = t[3:0] - v;
    pr_next = qbit ? pr_sub : t[3:0];
    d_next  = {d[6:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      d              <= 8'h00;
      v              <= 4'h0;
      pr             <= 4'h0;
      cnt            <= 3'd0;
      io_Quotient    <= 8'h00;
      io_Remainder   <= 4'h0;
      io_busy        <= 1'b0;
      io_done        <= 1'b0;
      io_div_by_zero <= 1'b0;
    end else begin
      io_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (io_start) begin
            d   <= io_Dividend;
            v   <= io_Divisor;
            pr  <= 4'h0;
            cnt <= 3'd0;
            if (io_Divisor == 4'h0) begin
              // Divide by zero short-circuits straight to DONE without iterating.
              state          <= DONE;
              io_Quotient    <= 8'hFF;
              io_Remainder   <= io_Dividend[3:0];
              io_div_by_zero <= 1'b1;
              io_done        <= 1'b1;
            end else begin
              state   <= CALC;
              io_busy <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          d   <= d_next;
          pr  <= pr_next;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            // Results are taken from the step being computed now, not the stale registers.
            state          <= DONE;
            io_busy        <= 1'b0;
            io_done        <= 1'b1;
            io_Quotient    <= d_next;
            io_Remainder   <= pr_next;
            io_div_by_zero <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          io_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_carlosgs99_div_8by4.sv
// tb/tb_tt_um_carlosgs99_div_8by4.sv - self-checking bench for the 8-by-4 restoring divider
module tb_tt_um_carlosgs99_div_8by4;

  logic       clk;
  logic       rst;
  logic [7:0] io_Dividend;
  logic [3:0] io_Divisor;
  logic       io_start;
  logic [7:0] io_Quotient;
  logic [3:0] io_Remainder;
  logic       io_busy;
  logic       io_done;
  logic       io_div_by_zero;

  int checks;
  int errors;

  tt_um_carlosgs99_div_8by4 dut (
    .clk            (clk),
    .rst            (rst),
    .io_Dividend    (io_Dividend),
    .io_Divisor     (io_Divisor),
    .io_start       (io_start),
    .io_Quotient    (io_Quotient),
    .io_Remainder   (io_Remainder),
    .io_busy        (io_busy),
    .io_done        (io_done),
    .io_div_by_zero (io_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 4x4 multiplier as a shift-and-add over the divisor bits.
  function automatic int mul_model(input int a, input int b);
    int acc;
    acc = 0;
    for (int i = 0; i < 4; i++)
      if (((b >> i) & 1) != 0) acc = acc + (a << i);
    return acc;
  endfunction

  // One full operation: start for a single cycle, wait for done, check everything.
  task automatic do_op(input int a, input int b);
    int k;
    int eq, er, edz, elat;
    eq   = (b == 0) ? 255 : a / b;
    er   = (b == 0) ? (a & 15) : a % b;
    edz  = (b == 0) ? 1 : 0;
    elat = (b == 0) ? 0 : 8;
    io_Dividend = 8'(a);
    io_Divisor  = 4'(b);
    io_start    = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    k = 0;
    while (io_done !== 1'b1 && k < 20) begin
      checks++;
      if (io_busy !== (b != 0)) begin
        errors++;
        $display("FAIL busy_during_op %0d/%0d k=%0d: got %b want %b", a, b, k, io_busy, (b != 0));
      end
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != elat) begin
      errors++;
      $display("FAIL latency %0d/%0d: got %0d want %0d", a, b, k, elat);
    end
    checks++;
    if (io_Quotient !== 8'(eq) || io_Remainder !== 4'(er) || io_div_by_zero !== 1'(edz)) begin
      errors++;
      $display("FAIL result %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%0d",
               a, b, io_Quotient, io_Remainder, io_div_by_zero, eq, er, edz);
    end
    checks++;
    if (io_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_done %0d/%0d: got %b want 0", a, b, io_busy);
    end
    if (b != 0) begin
      checks++;
      if (mul_model(int'(io_Quotient), b) + int'(io_Remainder) != a || int'(io_Remainder) >= b) begin
        errors++;
        $display("FAIL invariant %0d/%0d: got q=%0d r=%0d want q*b+r=%0d and r<%0d",
                 a, b, io_Quotient, io_Remainder, a, b);
      end
    end
    @(negedge clk);
    checks++;
    if (io_done !== 1'b0 || io_Quotient !== 8'(eq) || io_Remainder !== 4'(er)) begin
      errors++;
      $display("FAIL done_pulse_hold %0d/%0d: got done=%b q=%0d r=%0d want done=0 q=%0d r=%0d",
               a, b, io_done, io_Quotient, io_Remainder, eq, er);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io_start = 1'b1;  // start coincident with reset must be dropped
    io_Dividend = 8'd77;
    io_Divisor  = 4'd3;
    repeat (2) @(negedge clk);
    checks++;
    if (io_Quotient !== 8'h00 || io_Remainder !== 4'h0 || io_busy !== 1'b0 ||
        io_done !== 1'b0 || io_div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got q=%h r=%h busy=%b done=%b z=%b want all 0",
               io_Quotient, io_Remainder, io_busy, io_done, io_div_by_zero);
    end
    rst = 1'b0;
    io_start = 1'b0;
    @(negedge clk);
    checks++;
    if (io_busy !== 1'b0 || io_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_dropped: got busy=%b done=%b want 0 0", io_busy, io_done);
    end
  endtask

  task automatic test_basic_and_edges();
    do_op(200, 13);
    do_op(255, 1);
    do_op(7, 9);
    do_op(0, 5);
    do_op(225, 15);
  endtask

  task automatic test_div_by_zero();
    do_op(8'hA7, 0);
    do_op(100, 7);  // flag must clear
    do_op(0, 0);
    do_op(255, 15);
  endtask

  task automatic test_ignore_start();
    int k;
    io_Dividend = 8'd100;
    io_Divisor  = 4'd7;
    io_start    = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    k = 0;
    while (io_done !== 1'b1 && k < 20) begin
      if (k == 3) begin
        io_start    = 1'b1;
        io_Dividend = 8'd50;
        io_Divisor  = 4'd3;
      end else begin
        io_start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    io_start = 1'b0;
    checks++;
    if (k != 8 || io_Quotient !== 8'd14 || io_Remainder !== 4'd2) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d want lat=8 q=14 r=2", k, io_Quotient, io_Remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int as[4];
    int bs[4];
    int cyc, last, n;
    for (int i = 0; i < 4; i++) begin
      as[i] = int'($urandom_range(0, 255));
      bs[i] = int'($urandom_range(1, 15));
    end
    io_Dividend = 8'(as[0]);
    io_Divisor  = 4'(bs[0]);
    io_start    = 1'b1;
    cyc = 0;
    n = 0;
    last = -1;
    while (n < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (io_done === 1'b1) begin
        checks++;
        if (io_Quotient !== 8'(as[n] / bs[n]) || io_Remainder !== 4'(as[n] % bs[n])) begin
          errors++;
          $display("FAIL b2b_result %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                   as[n], bs[n], io_Quotient, io_Remainder, as[n] / bs[n], as[n] % bs[n]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 9) begin
            errors++;
            $display("FAIL b2b_gap: got %0d want 9", cyc - last);
          end
        end
        last = cyc;
        n++;
        io_Dividend = 8'(as[n]);
        io_Divisor  = 4'(bs[n]);
      end
    end
    io_start = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses want 3", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int seen;
    io_Dividend = 8'd99;
    io_Divisor  = 4'd4;
    io_start    = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (io_Quotient !== 8'h00 || io_Remainder !== 4'h0 || io_busy !== 1'b0 ||
        io_done !== 1'b0 || io_div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: got q=%h r=%h busy=%b done=%b z=%b want all 0",
               io_Quotient, io_Remainder, io_busy, io_done, io_div_by_zero);
    end
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (io_done === 1'b1 || io_busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d active cycles want 0", seen);
    end
    do_op(99, 4);
  endtask

  task automatic test_random();
    repeat (150) do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
  endtask

  task automatic test_exhaustive();
    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        do_op(a, b);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    io_start = 1'b0;
    io_Dividend = 8'h00;
    io_Divisor  = 4'h0;
    @(negedge clk);
    test_reset();
    test_basic_and_edges();
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
